// File: rtl/motor_pwm_if.sv
// Command/status bundle between the PID loop and one H-bridge PWM channel.
interface motor_pwm_if #(
  parameter int W     = 16,
  parameter int CNT_W = 12
);
  logic                    enable;
  logic signed [W-1:0]     u_in;
  logic                    u_valid;
  logic                    pwm;
  logic                    dir;
  logic                    brake;
  logic                    period_tick;
  logic                    sat;
  logic [CNT_W-1:0]        duty;

  modport master (output enable, u_in, u_valid,
                  input  pwm, dir, brake, period_tick, sat, duty);
  modport slave  (input  enable, u_in, u_valid,
                  output pwm, dir, brake, period_tick, sat, duty);
endinterface

// File: rtl/motor_pwm_driver.sv
// Saturating PWM + direction driver for one H-bridge channel, with dead time on reversal.
// Optional low-side braking at zero duty: define MOTOR_PWM_BRAKE_EN.
module motor_pwm_driver #(
  parameter int W        = 16,
  parameter int CNT_W    = 12,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 20
) (
  input  logic           clk,
  input  logic           reset,
  motor_pwm_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [W:0]       PERIOD_M = (W+1)'(PERIOD);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEADTIME - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt, dcnt, duty;
  logic signed [W-1:0] pending;
  logic                pwm_q, dir_q, dir_tgt, sat_q;

  logic signed [W-1:0] u_eff;
  logic [W:0]          mag;
  logic [CNT_W-1:0]    duty_nx, duty_cmp, cnt_nx;
  logic                sat_nx, dir_req, bnd, reverse;

  // A strobe in the boundary cycle bypasses the pending register.
  assign u_eff    = bus.u_valid ? bus.u_in : pending;
  assign mag      = u_eff[W-1] ? ((W+1)'(0) - {u_eff[W-1], u_eff}) : {1'b0, u_eff};
  assign sat_nx   = (mag > PERIOD_M);
  assign duty_nx  = sat_nx ? PERIOD_C : mag[CNT_W-1:0];
  assign dir_req  = (u_eff[W-1])   ? 1'b0 :
                    (u_eff != '0)  ? 1'b1 : dir_q;
  assign bnd      = (state != IDLE) && (cnt == '0);
  assign duty_cmp = bnd ? duty_nx : duty;
  assign cnt_nx   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  assign reverse  = bnd && (dir_req != dir_q) && (duty_nx != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      duty    <= '0;
      pending <= '0;
      pwm_q   <= 1'b0;
      dir_q   <= 1'b1;
      dir_tgt <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      if (bus.u_valid) pending <= bus.u_in;
      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
        dcnt  <= '0;
        pwm_q <= 1'b0;
      end else begin
        if (bnd) begin
          duty  <= duty_nx;
          sat_q <= sat_nx;
        end
        case (state)
          IDLE: begin
            state <= RUN;
            cnt   <= '0;
            pwm_q <= 1'b0;
          end
          RUN: begin
            cnt <= cnt_nx;
            if (reverse) begin
              // Direction is latched here so a strobe during dead time cannot retarget it.
              state   <= DEAD;
              dcnt    <= '0;
              dir_tgt <= dir_req;
              pwm_q   <= 1'b0;
            end else begin
              pwm_q <= (cnt < duty_cmp);
            end
          end
          DEAD: begin
            cnt  <= cnt_nx;
            dcnt <= dcnt + 1'b1;
            if (dcnt == DT_LAST) begin
              state <= RUN;
              dir_q <= dir_tgt;
              pwm_q <= (cnt < duty);
            end else begin
              pwm_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.dir         = dir_q;
  assign bus.sat         = sat_q;
  assign bus.duty        = duty;
  assign bus.period_tick = bnd;
`ifdef MOTOR_PWM_BRAKE_EN
  assign bus.brake       = (state == RUN) && (duty == '0);
`else
  assign bus.brake       = 1'b0;
`endif
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed scenarios plus randomized traffic against a period-level behavioural model.
module tb_motor_pwm_driver;
  localparam int W = 16, CNT_W = 12, PERIOD = 100, DEADTIME = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0, failures = 0;

  motor_pwm_if #(.W(W), .CNT_W(CNT_W)) bus ();

  motor_pwm_driver #(.W(W), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEADTIME(DEADTIME))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: running flag, period counter, dead-time countdown.
  int m_run, m_cnt, m_dead, m_duty, m_sat, m_dir, m_tgt, m_pend, m_pwm;
  always @(posedge clk) begin
    int v, mag, nd, want;
    bit entering;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_dead = 0; m_duty = 0; m_sat = 0;
      m_dir = 1; m_tgt = 1; m_pend = 0; m_pwm = 0;
    end else begin
      v = bus.u_valid ? int'($signed(bus.u_in)) : m_pend;
      if (bus.u_valid) m_pend = int'($signed(bus.u_in));
      entering = 0;
      if (!bus.enable) begin
        m_run = 0; m_cnt = 0; m_dead = 0; m_pwm = 0;
      end else if (!m_run) begin
        m_run = 1; m_cnt = 0; m_pwm = 0;
      end else begin
        if (m_cnt == 0) begin
          mag    = (v < 0) ? -v : v;
          nd     = (mag > PERIOD) ? PERIOD : mag;
          m_sat  = (mag > PERIOD) ? 1 : 0;
          m_duty = nd;
          want   = (v > 0) ? 1 : (v < 0) ? 0 : m_dir;
          if (m_dead == 0 && want != m_dir && nd != 0) begin
            m_dead = DEADTIME; m_tgt = want; entering = 1;
          end
        end
        if (entering) m_pwm = 0;
        else if (m_dead > 0) begin
          m_dead--;
          if (m_dead == 0) begin m_dir = m_tgt; m_pwm = (m_cnt < m_duty) ? 1 : 0; end
          else m_pwm = 0;
        end else m_pwm = (m_cnt < m_duty) ? 1 : 0;
        m_cnt = (m_cnt + 1) % PERIOD;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.enable = 1'b0; bus.u_valid = 1'b0; bus.u_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input int val);
    bus.u_in = 16'(val); bus.u_valid = 1'b1;
    @(negedge clk);
    bus.u_valid = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (bus.period_tick) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.pwm, bus.dir, bus.brake, bus.period_tick, bus.sat, bus.duty} !== {5'b01000, 12'd0}) begin
      failures++;
      $display("FAIL reset_state got pwm=%b dir=%b brake=%b tick=%b sat=%b duty=%0d want 0 1 0 0 0 0",
               bus.pwm, bus.dir, bus.brake, bus.period_tick, bus.sat, bus.duty);
    end
  endtask

  task automatic test_basic();
    bit ok; int hi = 0, tk = 0;
    strobe(30);
    bus.enable = 1'b1;
    wait_tick(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_first_tick got none want tick"); end
    for (int i = 1; i <= 2 * PERIOD; i++) begin
      @(negedge clk);
      hi += int'(bus.pwm); tk += int'(bus.period_tick);
      if (i == 1) begin
        checks++;
        if (bus.duty !== 12'd30 || bus.sat !== 1'b0 || bus.dir !== 1'b1) begin
          failures++;
          $display("FAIL basic_duty got duty=%0d sat=%b dir=%b want 30 0 1", bus.duty, bus.sat, bus.dir);
        end
      end
    end
    checks++; if (hi != 60) begin failures++; $display("FAIL basic_pwm_high got %0d want 60", hi); end
    checks++; if (tk != 2)  begin failures++; $display("FAIL basic_ticks got %0d want 2", tk); end
  endtask

  task automatic test_sat();
    bit ok; int hi = 0;
    repeat (10) @(negedge clk);
    strobe(500);
    wait_tick(ok);
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      hi += int'(bus.pwm);
      if (i == 1) begin
        checks++;
        if (bus.duty !== 12'd100 || bus.sat !== 1'b1) begin
          failures++; $display("FAIL sat_pos got duty=%0d sat=%b want 100 1", bus.duty, bus.sat);
        end
      end
    end
    checks++; if (!ok || hi != PERIOD) begin failures++; $display("FAIL sat_pwm_full got %0d want 100", hi); end
    repeat (10) @(negedge clk);
    strobe(-32768);
    wait_tick(ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || bus.dir !== 1'b0 || bus.duty !== 12'd100 || bus.sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg_min got dir=%b duty=%0d sat=%b want 0 100 1", bus.dir, bus.duty, bus.sat);
    end
    wait_tick(ok);
    hi = 0;
    for (int i = 1; i <= PERIOD; i++) begin @(negedge clk); hi += int'(bus.pwm); end
    checks++; if (!ok || hi != PERIOD) begin failures++; $display("FAIL sat_neg_full got %0d want 100", hi); end
  endtask

  task automatic test_reversal();
    bit ok; int hi = 0, early = 0;
    do_reset();
    strobe(40);
    bus.enable = 1'b1;
    wait_tick(ok);
    repeat (50) @(negedge clk);
    strobe(-40);
    wait_tick(ok);
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      hi += int'(bus.pwm);
      if (i <= DEADTIME) early += int'(bus.pwm);
      if (i == DEADTIME) begin
        checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL rev_dir_hold got %b want 1", bus.dir); end
      end
      if (i == DEADTIME + 1) begin
        checks++;
        if (bus.dir !== 1'b0 || bus.pwm !== 1'b1) begin
          failures++; $display("FAIL rev_resume got dir=%b pwm=%b want 0 1", bus.dir, bus.pwm);
        end
      end
    end
    checks++; if (!ok || early != 0) begin failures++; $display("FAIL rev_dead_pwm got %0d want 0", early); end
    checks++; if (hi != 35) begin failures++; $display("FAIL rev_pwm_high got %0d want 35", hi); end
  endtask

  task automatic test_zero();
    bit ok; int hi = 0, brk = 0, dbad = 0, want_brk;
`ifdef MOTOR_PWM_BRAKE_EN
    want_brk = PERIOD;
`else
    want_brk = 0;
`endif
    do_reset();
    strobe(40);
    bus.enable = 1'b1;
    wait_tick(ok);
    repeat (30) @(negedge clk);
    strobe(0);
    wait_tick(ok);
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      hi += int'(bus.pwm); brk += int'(bus.brake);
      if (bus.dir !== 1'b1) dbad++;
    end
    checks++;
    if (!ok || hi != 0 || dbad != 0 || bus.duty !== 12'd0) begin
      failures++; $display("FAIL zero_duty got hi=%0d dir_changes=%0d duty=%0d want 0 0 0", hi, dbad, bus.duty);
    end
    checks++; if (brk != want_brk) begin failures++; $display("FAIL zero_brake got %0d want %0d", brk, want_brk); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    strobe(40);
    bus.enable = 1'b1;
    wait_tick(ok);
    repeat (30) @(negedge clk);
    strobe(-40);
    wait_tick(ok);
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || bus.pwm !== 1'b0 || bus.period_tick !== 1'b0 || bus.dir !== 1'b1 || bus.duty !== 12'd40) begin
      failures++;
      $display("FAIL drop_idle got pwm=%b tick=%b dir=%b duty=%0d want 0 0 1 40",
               bus.pwm, bus.period_tick, bus.dir, bus.duty);
    end
    strobe(25);
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.period_tick !== 1'b1) begin failures++; $display("FAIL drop_reen_tick got %b want 1", bus.period_tick); end
    @(negedge clk);
    checks++;
    if (bus.duty !== 12'd25 || bus.dir !== 1'b1 || bus.period_tick !== 1'b0) begin
      failures++; $display("FAIL drop_reload got duty=%0d dir=%b tick=%b want 25 1 0", bus.duty, bus.dir, bus.period_tick);
    end
  endtask

  task automatic test_bypass();
    bit ok; int hi = 0;
    do_reset();
    strobe(10);
    bus.enable = 1'b1;
    wait_tick(ok);
    repeat (20) @(negedge clk);
    wait_tick(ok);
    bus.u_in = 16'(70); bus.u_valid = 1'b1;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.u_valid = 1'b0;
        checks++; if (bus.duty !== 12'd70) begin failures++; $display("FAIL bypass_duty got %0d want 70", bus.duty); end
      end
      hi += int'(bus.pwm);
    end
    checks++; if (!ok || hi != 70) begin failures++; $display("FAIL bypass_pwm got %0d want 70", hi); end
    repeat (10) @(negedge clk);
    strobe(20);
    repeat (10) @(negedge clk);
    strobe(55);
    wait_tick(ok);
    @(negedge clk);
    checks++; if (!ok || bus.duty !== 12'd55) begin failures++; $display("FAIL last_strobe got %0d want 55", bus.duty); end
  endtask

  task automatic test_random();
    int off = 0, sel;
    logic [CNT_W+4:0] got, exp;
    do_reset();
    bus.enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      exp = {m_pwm[0], m_dir[0],
`ifdef MOTOR_PWM_BRAKE_EN
             (m_run != 0 && m_dead == 0 && m_duty == 0),
`else
             1'b0,
`endif
             (m_run != 0 && m_cnt == 0), m_sat[0], CNT_W'(m_duty)};
      got = {bus.pwm, bus.dir, bus.brake, bus.period_tick, bus.sat, bus.duty};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random_cycle%0d got %h want %h", c, got, exp);
      end
      if (off > 0) begin off--; bus.enable = 1'b0; end
      else begin
        bus.enable = 1'b1;
        if ($urandom_range(0, 299) == 0) off = $urandom_range(1, 8);
      end
      bus.u_valid = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: bus.u_in = '0;
        1: bus.u_in = 16'sh8000;
        2: bus.u_in = 16'sh7fff;
        default: bus.u_in = 16'($signed($urandom_range(0, 300)) - 150);
      endcase
    end
    bus.u_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.u_valid = 1'b0; bus.u_in = '0;
    test_reset();
    test_basic();
    test_sat();
    test_reversal();
    test_zero();
    test_enable_drop();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
